rd_ptr_ctrl: RTL and testbench

//  Read-domain pointer/flag controller for the async FIFO, successor to the basic empty generator.

---
 rtl/rd_ptr_ctrl_pkg.sv | 30 +++
 rtl/rd_ptr_ctrl_if.sv | 25 ++
 rtl/rd_ptr_ctrl_ptr_sync.sv | 28 ++
 rtl/rd_ptr_ctrl.sv | 88 ++++++++
 tb/tb_rd_ptr_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/rd_ptr_ctrl_pkg.sv
// Shared pointer helpers for the async FIFO read-side controller.
// Gray/binary conversions work on any width up to PTR_MAX_W via zero extension.
package rd_ptr_ctrl_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic underflow;
  } rd_flags_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_ptr_ctrl_if.sv
// Read-side handshake and pointer bundle between the FIFO user and rd_ptr_ctrl.
interface rd_ptr_ctrl_if #(
  parameter int unsigned AW = 4
);
  logic          rd_rq;
  logic          clr_underflow;
  logic [AW:0]   wq_ptr;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rd_ack;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_level;
  logic          underflow;

  modport master (
    output rd_rq, clr_underflow, wq_ptr,
    input  raddr, rptr, rd_ack, empty, almost_empty, rd_level, underflow
  );

  modport slave (
    input  rd_rq, clr_underflow, wq_ptr,
    output raddr, rptr, rd_ack, empty, almost_empty, rd_level, underflow
  );
endinterface

// File: rtl/rd_ptr_ctrl_ptr_sync.sv
// Multi-flop synchroniser for the Gray write pointer into the read clock domain.
// Only built when RD_SYNC_EN is defined.
`ifdef RD_SYNC_EN
module ptr_sync #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             r_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`endif

// File: rtl/rd_ptr_ctrl.sv
// Read-domain pointer/flag controller: binary+Gray read pointer, empty, almost_empty, level, underflow.
// Define RD_SYNC_EN to synchronise a raw write-domain Gray pointer internally (SYNC_STAGES flops).
module rd_ptr_ctrl
  import rd_ptr_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AE_THRESH   = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         r_clk,
  input  logic         rst_n,
  rd_ptr_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rd_ptr_ctrl: DEPTH must be a power of 2 and >= 4");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("rd_ptr_ctrl: AE_THRESH must be below DEPTH");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rd_ptr_ctrl: SYNC_STAGES must be >= 2");
  end

  logic [PW-1:0] wq_sync;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin_q,  rbin_d;
  logic [PW-1:0] rptr_q,  rptr_d;
  logic [PW-1:0] lvl_q,   lvl_d;
  rd_flags_t     flags_q, flags_d;
  logic          rd_ack_c;

`ifdef RD_SYNC_EN
  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_ptr_sync (
    .r_clk (r_clk),
    .rst_n (rst_n),
    .d_i   (bus.wq_ptr),
    .q_o   (wq_sync)
  );
`else
  assign wq_sync = bus.wq_ptr;
`endif

  // Next-state: all pointer arithmetic is modulo 2^PW so lap wrap needs no special case.
  always_comb begin
    rd_ack_c = bus.rd_rq & ~flags_q.empty;
    rbin_d   = rbin_q + PW'(rd_ack_c);
    rptr_d   = PW'(bin2gray(PTR_MAX_W'(rbin_d)));
    wbin     = PW'(gray2bin(PTR_MAX_W'(wq_sync)));
    lvl_d    = wbin - rbin_d;

    flags_d              = flags_q;
    flags_d.empty        = (rptr_d == wq_sync);
    flags_d.almost_empty = (lvl_d <= PW'(AE_THRESH));
    // Set takes priority over a same-cycle clear.
    flags_d.underflow    = (bus.rd_rq & flags_q.empty) |
                           (flags_q.underflow & ~bus.clr_underflow);
  end

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q  <= '0;
      rptr_q  <= '0;
      lvl_q   <= '0;
      flags_q <= '{empty: 1'b1, almost_empty: 1'b1, underflow: 1'b0};
    end else begin
      rbin_q  <= rbin_d;
      rptr_q  <= rptr_d;
      lvl_q   <= lvl_d;
      flags_q <= flags_d;
    end
  end

  assign bus.raddr        = rbin_q[AW-1:0];
  assign bus.rptr         = rptr_q;
  assign bus.rd_ack       = rd_ack_c;
  assign bus.empty        = flags_q.empty;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.rd_level     = lvl_q;
  assign bus.underflow    = flags_q.underflow;

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Self-checking bench for rd_ptr_ctrl (default build, externally synchronised wq_ptr).
module tb_rd_ptr_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned AE    = 2;

  logic r_clk = 1'b0;
  logic rst_n;
  always #5 r_clk = ~r_clk;

  rd_ptr_ctrl_if #(.AW(AW)) bus ();

  rd_ptr_ctrl #(
    .DEPTH       (DEPTH),
    .AE_THRESH   (AE),
    .SYNC_STAGES (2)
  ) dut (
    .r_clk (r_clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: write and read counts as plain integers.
  int m_w, m_r, m_lvl;
  bit m_empty, m_ae, m_uf;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b & 31);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_r = 0; m_lvl = 0; m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
  endtask

  task automatic set_w(input int w);
    m_w = w;
    bus.wq_ptr = gray(w);
  endtask

  task automatic tick();
    bit ack;
    @(posedge r_clk);
    ack   = bus.rd_rq && !m_empty;
    m_uf  = (bus.rd_rq && m_empty) || (m_uf && !bus.clr_underflow);
    if (ack) m_r++;
    m_lvl   = (m_w - m_r) & 31;
    m_empty = (m_lvl == 0);
    m_ae    = (m_lvl <= int'(AE));
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    n_checks++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got %b want 1", bus.almost_empty); end
    n_checks++; if (bus.rd_level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", bus.rd_level); end
    n_checks++; if (bus.rptr !== 5'd0) begin n_fail++; $display("FAIL reset_rptr got %0d want 0", bus.rptr); end
    n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_uf got %b want 0", bus.underflow); end
    @(negedge r_clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL post_reset_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_fill();
    set_w(5);
    #1;
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL fill_latency_empty got %b want 1", bus.empty); end
    tick();
    n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty got %b want 0", bus.empty); end
    n_checks++; if (bus.rd_level !== 5'd5) begin n_fail++; $display("FAIL fill_level got %0d want 5", bus.rd_level); end
    n_checks++; if (bus.almost_empty !== 1'b0) begin n_fail++; $display("FAIL fill_ae got %b want 0", bus.almost_empty); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 5; i++) begin
      bus.rd_rq = 1'b1;
      #1;
      n_checks++; if (bus.rd_ack !== 1'b1) begin n_fail++; $display("FAIL drain_ack[%0d] got %b want 1", i, bus.rd_ack); end
      n_checks++; if (bus.raddr !== 4'(i)) begin n_fail++; $display("FAIL drain_raddr[%0d] got %0d want %0d", i, bus.raddr, i); end
      tick();
      n_checks++; if (bus.rd_level !== 5'(4 - i)) begin n_fail++; $display("FAIL drain_level[%0d] got %0d want %0d", i, bus.rd_level, 4 - i); end
      n_checks++; if (bus.almost_empty !== ((4 - i) <= 2)) begin n_fail++; $display("FAIL drain_ae[%0d] got %b want %b", i, bus.almost_empty, (4 - i) <= 2); end
    end
    bus.rd_rq = 1'b0;
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_underflow();
    bus.rd_rq = 1'b1;
    #1;
    n_checks++; if (bus.rd_ack !== 1'b0) begin n_fail++; $display("FAIL uf_ack got %b want 0", bus.rd_ack); end
    tick();
    n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set got %b want 1", bus.underflow); end
    n_checks++; if (bus.rptr !== 5'h07) begin n_fail++; $display("FAIL uf_rptr got %h want 07", bus.rptr); end
    bus.rd_rq = 1'b0;
    tick();
    n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL uf_hold got %b want 1", bus.underflow); end
    bus.rd_rq = 1'b1; bus.clr_underflow = 1'b1;
    tick();
    n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set_wins got %b want 1", bus.underflow); end
    bus.rd_rq = 1'b0;
    tick();
    n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear got %b want 0", bus.underflow); end
    bus.clr_underflow = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && (m_w - m_r) < int'(DEPTH)) set_w(m_w + 1);
      bus.rd_rq         = 1'($urandom_range(0, 1));
      bus.clr_underflow = ($urandom_range(0, 7) == 0);
      #1;
      n_checks++; if (bus.rd_ack !== (bus.rd_rq && !m_empty)) begin n_fail++; $display("FAIL rnd_ack c%0d got %b want %b", c, bus.rd_ack, bus.rd_rq && !m_empty); end
      n_checks++; if (bus.raddr !== 4'(m_r & 15)) begin n_fail++; $display("FAIL rnd_raddr c%0d got %0d want %0d", c, bus.raddr, m_r & 15); end
      tick();
      n_checks++; if (bus.rptr !== gray(m_r)) begin n_fail++; $display("FAIL rnd_rptr c%0d got %h want %h", c, bus.rptr, gray(m_r)); end
      n_checks++; if (bus.rd_level !== 5'(m_lvl)) begin n_fail++; $display("FAIL rnd_level c%0d got %0d want %0d", c, bus.rd_level, m_lvl); end
      n_checks++; if (bus.empty !== m_empty) begin n_fail++; $display("FAIL rnd_empty c%0d got %b want %b", c, bus.empty, m_empty); end
      n_checks++; if (bus.almost_empty !== m_ae) begin n_fail++; $display("FAIL rnd_ae c%0d got %b want %b", c, bus.almost_empty, m_ae); end
      n_checks++; if (bus.underflow !== m_uf) begin n_fail++; $display("FAIL rnd_uf c%0d got %b want %b", c, bus.underflow, m_uf); end
    end
    bus.rd_rq = 1'b0; bus.clr_underflow = 1'b0;
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    bus.rd_rq = 1'b1;
    while (!m_empty && guard < 40) begin tick(); guard++; end
    bus.rd_rq = 1'b0;
    guard = 0;
    while ((m_r & 31) != 30 && guard < 64) begin
      set_w(m_w + 1);
      tick();
      bus.rd_rq = 1'b1;
      tick();
      bus.rd_rq = 1'b0;
      guard++;
    end
    n_checks++; if (bus.rptr !== 5'h11) begin n_fail++; $display("FAIL wrap_rptr30 got %h want 11", bus.rptr); end
    set_w(m_w + ((3 - (m_w & 31)) & 31));
    tick();
    n_checks++; if (bus.rd_level !== 5'd5) begin n_fail++; $display("FAIL wrap_level got %0d want 5", bus.rd_level); end
    n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got %b want 0", bus.empty); end
    n_checks++; if (bus.raddr !== 4'd14) begin n_fail++; $display("FAIL wrap_raddr got %0d want 14", bus.raddr); end
  endtask

  task automatic test_reset_mid();
    set_w(m_w + 2);
    tick();
    n_checks++; if (bus.rd_level !== 5'd7) begin n_fail++; $display("FAIL mid_pre_level got %0d want 7", bus.rd_level); end
    bus.rd_rq = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty got %b want 1", bus.empty); end
    n_checks++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL mid_ae got %b want 1", bus.almost_empty); end
    n_checks++; if (bus.rd_level !== 5'd0) begin n_fail++; $display("FAIL mid_level got %0d want 0", bus.rd_level); end
    n_checks++; if (bus.rptr !== 5'd0) begin n_fail++; $display("FAIL mid_rptr got %h want 0", bus.rptr); end
    n_checks++; if (bus.raddr !== 4'd0) begin n_fail++; $display("FAIL mid_raddr got %0d want 0", bus.raddr); end
    n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL mid_uf got %b want 0", bus.underflow); end
    n_checks++; if (bus.rd_ack !== 1'b0) begin n_fail++; $display("FAIL mid_ack got %b want 0", bus.rd_ack); end
    bus.rd_rq = 1'b0;
    model_reset();
    set_w(0);
    @(negedge r_clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL mid_post_empty got %b want 1", bus.empty); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rd_rq = 1'b0;
    bus.clr_underflow = 1'b0;
    set_w(0);
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_underflow();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
